// File: rtl/repairmb_pkg.sv
// Shared definitions for the MBINIT REPAIRMB partner sequencer: sideband
// message codes, sequencer state encoding and functional-lane encodings.
package repairmb_pkg;

  typedef enum logic [3:0] {
    MSG_NONE       = 4'd0,
    MSG_START_REQ  = 4'd1,
    MSG_START_RESP = 4'd2,
    MSG_DEG_REQ    = 4'd3,
    MSG_DEG_RESP   = 4'd4,
    MSG_END_REQ    = 4'd5,
    MSG_END_RESP   = 4'd6
  } msg_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_START_REQ,
    ST_TX_START_RESP,
    ST_W_DEG_REQ,
    ST_CHECK,
    ST_W_CHECK,
    ST_TX_DEG_RESP,
    ST_W_END_REQ,
    ST_TX_END_RESP,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] LANES_NONE  = 2'b00;
  localparam logic [1:0] LANES_LOWER = 2'b01;
  localparam logic [1:0] LANES_UPPER = 2'b10;
  localparam logic [1:0] LANES_ALL   = 2'b11;

  function automatic logic is_tx_state(input state_t s);
    return s inside {ST_TX_START_RESP, ST_TX_DEG_RESP, ST_TX_END_RESP};
  endfunction

  // States in which the wait-timeout counter advances.
  function automatic logic is_timed_state(input state_t s);
    return s inside {ST_W_START_REQ, ST_W_DEG_REQ, ST_W_CHECK, ST_W_END_REQ,
                     ST_TX_START_RESP, ST_TX_DEG_RESP, ST_TX_END_RESP};
  endfunction

  function automatic msg_t tx_msg_for(input state_t s);
    case (s)
      ST_TX_START_RESP: return MSG_START_RESP;
      ST_TX_DEG_RESP:   return MSG_DEG_RESP;
      ST_TX_END_RESP:   return MSG_END_RESP;
      default:          return MSG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/repairmb_sb_tx_hs.sv
// Sideband TX valid/ack hold register: a load pulse raises valid with its
// message latched; valid and message drop the cycle after an accepted ack.
module repairmb_sb_tx_hs
  import repairmb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       load_i,
  input  msg_t       load_msg_i,
  input  logic       ack_i,
  output logic       valid_o,
  output logic [3:0] msg_o
);

  logic valid_q;
  msg_t msg_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      valid_q <= 1'b0;
      msg_q   <= MSG_NONE;
    end else if (load_i) begin
      valid_q <= 1'b1;
      msg_q   <= load_msg_i;
    end else if (valid_q && ack_i) begin
      valid_q <= 1'b0;
      msg_q   <= MSG_NONE;
    end
  end

  assign valid_o = valid_q;
  assign msg_o   = msg_q;

endmodule

// File: rtl/repairmb_partner_seq.sv
// Partner-side REPAIRMB sequencer: tracks the START / APPLY_DEGRADE / END
// sideband handshake, drives the lane checker and acts on its verdict.
module repairmb_partner_seq
  import repairmb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_REPEATS    = 1,
  parameter int CNT_W          = 24
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_sb_rx_valid,
  input  logic [3:0] i_sb_rx_msg,
  input  logic [1:0] i_sb_rx_lanes,
  input  logic       i_sb_tx_ack,
  input  logic       i_tx_d2c_en,
  input  logic       i_done_check,
  input  logic       i_go_to_repeat,
  input  logic       i_go_to_train_error,
  input  logic       i_continue,
  output logic       o_start_check,
  output logic       o_second_check,
  output logic [1:0] o_functional_lanes,
  output logic       o_tx_d2c_en,
  output logic       o_sb_tx_valid,
  output logic [3:0] o_sb_tx_msg,
  output logic       o_done,
  output logic       o_train_error
);

  localparam int REP_W = $clog2(MAX_REPEATS + 2);
  localparam logic [REP_W-1:0] REP_LIMIT = REP_W'(MAX_REPEATS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic             rep_flag_q, rep_flag_d;
  logic             second_q, second_d;
  logic [1:0]       lanes_q, lanes_d;
  logic             tx_load_q, tx_load_d;
  msg_t             tx_load_msg_q, tx_load_msg_d;
  logic             start_check_q, done_q, err_q, d2c_q;
  logic             tx_valid, ack_ok, timeout, verdict_ok;

  assign ack_ok     = i_sb_tx_ack && tx_valid;
  assign timeout    = (cnt_q == CNT_LAST);
  assign rep_inc    = rep_cnt_q + REP_W'(1);
  assign verdict_ok = i_done_check && (i_go_to_train_error || i_go_to_repeat || i_continue);

  always_comb begin
    state_d    = state_q;
    rep_cnt_d  = rep_cnt_q;
    rep_flag_d = rep_flag_q;
    second_d   = second_q;
    lanes_d    = lanes_q;
    // Expected events are tested before the timeout so they win a tie.
    case (state_q)
      ST_IDLE: state_d = ST_W_START_REQ;
      ST_W_START_REQ: begin
        if (i_sb_rx_valid && i_sb_rx_msg == MSG_START_REQ) state_d = ST_TX_START_RESP;
        else if (timeout)                                  state_d = ST_ERR;
      end
      ST_TX_START_RESP: begin
        if (ack_ok)       state_d = ST_W_DEG_REQ;
        else if (timeout) state_d = ST_ERR;
      end
      ST_W_DEG_REQ: begin
        if (i_sb_rx_valid && i_sb_rx_msg == MSG_DEG_REQ) begin
          lanes_d = i_sb_rx_lanes;
          state_d = ST_CHECK;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_CHECK: state_d = ST_W_CHECK;
      ST_W_CHECK: begin
        if (verdict_ok) begin
          if (i_go_to_train_error) begin
            state_d = ST_ERR;
          end else begin
            rep_flag_d = i_go_to_repeat;
            state_d    = ST_TX_DEG_RESP;
          end
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_TX_DEG_RESP: begin
        if (ack_ok) begin
          rep_flag_d = 1'b0;
          if (rep_flag_q) begin
            rep_cnt_d = rep_inc;
            second_d  = 1'b1;
            state_d   = (rep_inc > REP_LIMIT) ? ST_ERR : ST_W_DEG_REQ;
          end else begin
            state_d = ST_W_END_REQ;
          end
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_W_END_REQ: begin
        if (i_sb_rx_valid && i_sb_rx_msg == MSG_END_REQ) state_d = ST_TX_END_RESP;
        else if (timeout)                                state_d = ST_ERR;
      end
      ST_TX_END_RESP: begin
        if (ack_ok)       state_d = ST_DONE;
        else if (timeout) state_d = ST_ERR;
      end
      default: state_d = state_q;
    endcase

    if (state_d != state_q || !is_timed_state(state_q)) cnt_d = '0;
    else                                               cnt_d = cnt_q + CNT_W'(1);

    if (!i_enable) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      rep_cnt_d  = '0;
      rep_flag_d = 1'b0;
      second_d   = 1'b0;
      lanes_d    = LANES_NONE;
    end

    tx_load_d     = is_tx_state(state_d) && (state_d != state_q);
    tx_load_msg_d = tx_msg_for(state_d);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rep_cnt_q     <= '0;
      rep_flag_q    <= 1'b0;
      second_q      <= 1'b0;
      lanes_q       <= LANES_NONE;
      tx_load_q     <= 1'b0;
      tx_load_msg_q <= MSG_NONE;
      start_check_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      d2c_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      rep_flag_q    <= rep_flag_d;
      second_q      <= second_d;
      lanes_q       <= lanes_d;
      tx_load_q     <= tx_load_d;
      tx_load_msg_q <= tx_load_msg_d;
      start_check_q <= (state_d == ST_CHECK);
      done_q        <= (state_d == ST_DONE);
      err_q         <= (state_d == ST_ERR);
      d2c_q         <= i_tx_d2c_en;
    end
  end

  repairmb_sb_tx_hs u_tx_hs (
    .clk        (CLK),
    .rst        (rst),
    .clear_i    (!i_enable),
    .load_i     (tx_load_q),
    .load_msg_i (tx_load_msg_q),
    .ack_i      (i_sb_tx_ack),
    .valid_o    (tx_valid),
    .msg_o      (o_sb_tx_msg)
  );

  assign o_sb_tx_valid      = tx_valid;
  assign o_start_check      = start_check_q;
  assign o_second_check     = second_q;
  assign o_functional_lanes = lanes_q;
  assign o_tx_d2c_en        = d2c_q;
  assign o_done             = done_q;
  assign o_train_error      = err_q;

endmodule

// File: doc/repairmb_partner_seq.md
Name: repairmb_partner_seq

Overview:
Partner-side sequencer for the MBINIT REPAIRMB sub-state. It tracks the sideband handshake with the link partner (start, apply-degrade, end) and captures the functional-lane vector the partner sends. It drives the REPAIRMB lane checker with start and second-check pulses, then acts on the checker's verdict: continue, repeat or train-error. It sits between the MBINIT LTSM top, the sideband message interface and the checker instance.

Parameters:
TIMEOUT_CYCLES, 16, cycles allowed in any wait state before declaring train error. Set to the 8 ms equivalent in product builds.
MAX_REPEATS, 1, number of repeat verdicts tolerated before forcing train error.
CNT_W, 24, width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
CLK  in  1  block clock
rst  in  1  synchronous active-high reset
i_enable  in  1  level; LTSM is in REPAIRMB. Deassertion aborts to IDLE.
i_sb_rx_valid  in  1  one-cycle pulse; received sideband message valid
i_sb_rx_msg  in  4  received message code
i_sb_rx_lanes  in  2  functional-lane field carried with APPLY_DEGRADE_REQ
i_sb_tx_ack  in  1  sideband TX accepted the current message
i_tx_d2c_en  in  1  transmitter-initiated data-to-clock enable, forwarded to the checker
i_done_check  in  1  checker verdict valid (pulse)
i_go_to_repeat  in  1  checker verdict
i_go_to_train_error  in  1  checker verdict
i_continue  in  1  checker verdict
o_start_check  out  1  one-cycle pulse to the checker
o_second_check  out  1  level; high on passes after a repeat
o_functional_lanes  out  2  captured lanes to the checker
o_tx_d2c_en  out  1  registered copy of i_tx_d2c_en
o_sb_tx_valid  out  1  TX request; held until ack
o_sb_tx_msg  out  4  TX message code
o_done  out  1  level; REPAIRMB completed successfully
o_train_error  out  1  level; REPAIRMB failed

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE.
  - Repeat count and timeout counter are 0.
  - Second-check flag is 0.
- States:
  - IDLE: leave when i_enable=1; go to W_START_REQ.
  - W_START_REQ: on rx START_REQ go to TX_START_RESP.
  - TX_START_RESP: send START_RESP; on ack go to W_DEG_REQ.
  - W_DEG_REQ: on rx APPLY_DEGRADE_REQ, capture i_sb_rx_lanes into o_functional_lanes and go to CHECK.
  - CHECK: o_start_check=1 for exactly one cycle, then W_CHECK.
  - W_CHECK: wait for i_done_check.
    - i_go_to_train_error -> ERR.
    - i_go_to_repeat -> TX_DEG_RESP with the repeat flag set.
    - i_continue -> TX_DEG_RESP.
    - Verdict priority is train_error > repeat > continue.
  - TX_DEG_RESP: send APPLY_DEGRADE_RESP; on ack:
    - if the repeat flag is set: increment the repeat count and set o_second_check=1.
    - if the count now exceeds MAX_REPEATS, go to ERR; otherwise go to W_DEG_REQ.
    - if the repeat flag is clear, go to W_END_REQ.
  - W_END_REQ: on rx END_REQ go to TX_END_RESP.
  - TX_END_RESP: send END_RESP; on ack go to DONE.
  - DONE: o_done=1.
  - ERR: o_train_error=1.
  - DONE and ERR are held until i_enable=0, then IDLE.
- Sideband TX:
  - o_sb_tx_valid rises in the cycle after entering a TX_* state.
  - o_sb_tx_msg is stable while valid is high.
  - Valid drops in the cycle after i_sb_tx_ack.
  - An ack that arrives while valid=0 is ignored.
- Sideband RX: a message code that is unexpected in the current state is ignored; it causes no state change and no counter reset.
- Timeout:
  - The counter runs in W_START_REQ, W_DEG_REQ, W_CHECK, W_END_REQ and all TX_* states.
  - It clears on every state change.
  - When it reaches TIMEOUT_CYCLES-1, the next state is ERR.
  - An expected event in that same cycle wins over the timeout.
- i_enable=0 in any state:
  - Next cycle is IDLE.
  - All outputs return to reset values; counters, second-check flag and o_functional_lanes clear.
- rst mid-operation: identical to the reset row above, taking effect on the next CLK edge.
- o_tx_d2c_en is registered from i_tx_d2c_en every cycle except during reset.

Decomposition:
- Shared package repairmb_pkg:
  - message codes: START_REQ=1, START_RESP=2, APPLY_DEGRADE_REQ=3, APPLY_DEGRADE_RESP=4, END_REQ=5, END_RESP=6.
  - state encoding.
  - lane encodings: 00 none, 01 lower, 10 upper, 11 all.
- One sub-module, repairmb_sb_tx_hs: the valid/ack hold register with its message latch. The FSM and counters stay in the top module.

Test Plan:
1. Happy path: enable; rx START_REQ; ack; rx DEG_REQ lanes=11; checker returns continue; ack; rx END_REQ; ack -> o_done=1, o_second_check stays 0, TX codes 2, 4, 6 in order.
2. Single repeat: lanes=01 -> repeat; ack; second rx DEG_REQ lanes=01; continue -> o_second_check=1 on the second o_start_check pulse, final o_done=1.
3. Repeat overflow, MAX_REPEATS=1: two repeat verdicts -> o_train_error=1 immediately after the second DEG_RESP ack.
4. Timeout: hold W_START_REQ with no rx for 16 cycles -> o_train_error=1 on cycle 16. Also: rx START_REQ on cycle 15 -> no error.
5. Abort and reset: drop i_enable while o_sb_tx_valid=1 -> next cycle all outputs 0, state IDLE. Assert rst in W_CHECK -> same result. Re-enable and run the happy path -> passes.
6. Unexpected messages: rx END_REQ while in W_DEG_REQ -> no state change. ack while idle -> ignored.
